// File: rtl/pixel_frame_fifo_if.sv
// Avalon-ST pixel stream bundle: {data, sop, eop} plus valid/ready handshake.
// Latency: none (wires only).
// Backpressure: ready flows from slave to master; a beat moves when valid & ready.
// Signals: data[WIDTH-1:0], sop, eop, valid (master->slave); ready (slave->master).
interface pixel_frame_fifo_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] data;
  logic             sop;
  logic             eop;
  logic             valid;
  logic             ready;

  modport master (output data, sop, eop, valid, input ready);
  modport slave  (input data, sop, eop, valid, output ready);
endinterface

// File: rtl/pixel_frame_fifo.sv
// Frame-aligned show-ahead pixel FIFO between the filter selection stage and the display path.
// Latency: a beat accepted into an empty FIFO is at the source one cycle later.
// Backpressure: snk.ready depends on registered state only (!full, or 1 while hunting for sop).
//
// Ports:
//   clk, reset     : clock (rising edge), asynchronous active-low reset
//   snk (slave)    : sink side   -- data_in/sop_in/eop_in/valid_in in, ready_out out
//   src (master)   : source side -- data_out/sop_out/eop_out/valid_out out, ready_in in
//   fill_level     : registered number of stored entries, 0..DEPTH
//   frame_err      : registered one-cycle pulse, the cycle after a malformed beat is accepted
// Optional: define PIXEL_FRAME_FIFO_LENCHECK_EN to also flag frames whose length != FRAME_PIXELS.
module pixel_frame_fifo #(
  parameter int WIDTH        = 12,
  parameter int DEPTH        = 16,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                     clk,
  input  logic                     reset,
  pixel_frame_fifo_if.slave        snk,
  pixel_frame_fifo_if.master       src,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_PIXELS + 1);

  typedef enum logic {WAIT_SOP = 1'b0, IN_FRAME = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      fill_q;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH+1:0] mem_q [DEPTH];

  logic full, empty, accept, wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // While hunting for sop every beat is taken (and mostly dropped), so ready stays high there.
  assign snk.ready = !full || (state_q == WAIT_SOP);
  assign accept    = snk.valid && snk.ready;
  assign rd_en     = !empty && src.ready;

  assign src.valid = !empty;
  assign {src.sop, src.eop, src.data} = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign fill_level = fill_q;
  assign frame_err  = frame_err_q;

  // Pixel count saturates instead of wrapping so an overlong frame never aliases a legal length.
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      WAIT_SOP: begin
        // A sop arriving while full cannot be stored; it is dropped and the whole frame is
        // discarded by staying here until the next sop.
        if (accept && snk.sop && !full) begin
          wr_en   = 1'b1;
          cnt_d   = CW'(1);
          state_d = snk.eop ? WAIT_SOP : IN_FRAME;
        end
      end
      IN_FRAME: begin
        if (accept && !full) begin
          wr_en = 1'b1;
          if (snk.sop) begin
            // Premature sop: the beat starts a fresh frame.
            cnt_d       = CW'(1);
            frame_err_d = 1'b1;
            if (snk.eop) state_d = WAIT_SOP;
          end else begin
            cnt_d = cnt_inc;
            if (snk.eop) begin
              state_d = WAIT_SOP;
`ifdef PIXEL_FRAME_FIFO_LENCHECK_EN
              frame_err_d = (cnt_inc != CW'(FRAME_PIXELS));
`endif
            end
          end
        end
      end
      default: state_d = WAIT_SOP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_SOP;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {snk.sop, snk.eop, snk.data};
  end

endmodule

// File: tb/tb_pixel_frame_fifo.sv
// Directed self-checking bench for pixel_frame_fifo (DEPTH=16, FRAME_PIXELS=4).
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
// Length-error expectations follow PIXEL_FRAME_FIFO_LENCHECK_EN.
module tb_pixel_frame_fifo;

  logic       clk;
  logic       reset;
  logic [4:0] fill_level;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PIXEL_FRAME_FIFO_LENCHECK_EN
  logic len_err_exp = 1'b1;
`else
  logic len_err_exp = 1'b0;
`endif

  pixel_frame_fifo_if #(.WIDTH(12)) snk_if ();
  pixel_frame_fifo_if #(.WIDTH(12)) src_if ();

  pixel_frame_fifo #(.WIDTH(12), .DEPTH(16), .FRAME_PIXELS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .snk        (snk_if),
    .src        (src_if),
    .fill_level (fill_level),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] d, input logic s, input logic e, input logic v);
    snk_if.data  = d;
    snk_if.sop   = s;
    snk_if.eop   = e;
    snk_if.valid = v;
  endtask

  task automatic head(input string tag, input logic [11:0] d, input logic s, input logic e);
    check({tag, "_valid"}, 32'(src_if.valid), 32'd1);
    check({tag, "_data"},  32'(src_if.data),  32'(d));
    check({tag, "_sop"},   32'(src_if.sop),   32'(s));
    check({tag, "_eop"},   32'(src_if.eop),   32'(e));
  endtask

  initial begin
    reset = 1'b0;
    drive(12'h000, 1'b0, 1'b0, 1'b0);
    src_if.ready = 1'b1;
    step();
    step();

    // Reset state
    check("rst_valid", 32'(src_if.valid), 32'd0);
    check("rst_ready", 32'(snk_if.ready), 32'd1);
    check("rst_fill",  32'(fill_level),   32'd0);
    check("rst_err",   32'(frame_err),    32'd0);
    check("rst_data",  32'(src_if.data),  32'd0);
    reset = 1'b1;
    step();

    // Beats before any sop are discarded
    drive(12'h111, 1'b0, 1'b0, 1'b1); step();
    check("presop1_valid", 32'(src_if.valid), 32'd0);
    check("presop1_ready", 32'(snk_if.ready), 32'd1);
    drive(12'h222, 1'b0, 1'b0, 1'b1); step();
    check("presop2_valid", 32'(src_if.valid), 32'd0);
    drive(12'h333, 1'b0, 1'b0, 1'b1); step();
    check("presop3_valid", 32'(src_if.valid), 32'd0);
    check("presop3_fill",  32'(fill_level),   32'd0);
    check("presop3_ready", 32'(snk_if.ready), 32'd1);

    // Well-formed 4-beat frame, streamed through with 1-cycle latency
    drive(12'hA00, 1'b1, 1'b0, 1'b1); step();
    head("a0", 12'hA00, 1'b1, 1'b0);
    check("a0_err", 32'(frame_err), 32'd0);
    drive(12'hA01, 1'b0, 1'b0, 1'b1); step();
    head("a1", 12'hA01, 1'b0, 1'b0);
    check("a1_fill", 32'(fill_level), 32'd1);
    drive(12'hA02, 1'b0, 1'b0, 1'b1); step();
    head("a2", 12'hA02, 1'b0, 1'b0);
    drive(12'hA03, 1'b0, 1'b1, 1'b1); step();
    head("a3", 12'hA03, 1'b0, 1'b1);
    check("a3_err", 32'(frame_err), 32'd0);
    drive(12'h000, 1'b0, 1'b0, 1'b0); step();
    check("a_end_valid", 32'(src_if.valid), 32'd0);
    check("a_end_fill",  32'(fill_level),   32'd0);
    check("a_end_err",   32'(frame_err),    32'd0);

    // Fill to DEPTH with the sink stalled
    src_if.ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(12'hB00 + 12'(i), (i == 0), 1'b0, 1'b1);
      step();
      check("fill_lvl", 32'(fill_level), 32'(i + 1));
      if (i < 15) check("fill_ready", 32'(snk_if.ready), 32'd1);
    end
    check("full_ready", 32'(snk_if.ready), 32'd0);
    head("full_head", 12'hB00, 1'b1, 1'b0);
    drive(12'hB10, 1'b0, 1'b1, 1'b1); step();
    check("full_hold_fill",  32'(fill_level),   32'd16);
    check("full_hold_ready", 32'(snk_if.ready), 32'd0);
    // One read while full and valid_in high: no write that cycle
    src_if.ready = 1'b1; step();
    check("full_rd_fill",  32'(fill_level),   32'd15);
    check("full_rd_ready", 32'(snk_if.ready), 32'd1);
    head("full_rd_head", 12'hB01, 1'b0, 1'b0);
    src_if.ready = 1'b0; step();
    check("refill_fill", 32'(fill_level), 32'd16);
    drive(12'h000, 1'b0, 1'b0, 1'b0);
    src_if.ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      head("drain", 12'hB00 + 12'(i), 1'b0, (i == 16));
      step();
    end
    check("drain_valid", 32'(src_if.valid), 32'd0);
    check("drain_fill",  32'(fill_level),   32'd0);

    // 3-beat frame: short against FRAME_PIXELS=4
    drive(12'hC00, 1'b1, 1'b0, 1'b1); step();
    head("c0", 12'hC00, 1'b1, 1'b0);
    check("c0_err", 32'(frame_err), 32'd0);
    drive(12'hC01, 1'b0, 1'b0, 1'b1); step();
    check("c1_err", 32'(frame_err), 32'd0);
    drive(12'hC02, 1'b0, 1'b1, 1'b1); step();
    head("c2", 12'hC02, 1'b0, 1'b1);
    check("c2_len_err", 32'(frame_err), 32'(len_err_exp));
    drive(12'h000, 1'b0, 1'b0, 1'b0); step();
    check("c_end_err",   32'(frame_err),    32'd0);
    check("c_end_valid", 32'(src_if.valid), 32'd0);

    // Premature sop on beat 2; new 4-beat frame D01..D04 forwarded intact
    drive(12'hD00, 1'b1, 1'b0, 1'b1); step();
    head("d0", 12'hD00, 1'b1, 1'b0);
    check("d0_err", 32'(frame_err), 32'd0);
    drive(12'hD01, 1'b1, 1'b0, 1'b1); step();
    head("d1", 12'hD01, 1'b1, 1'b0);
    check("d1_sop_err", 32'(frame_err), 32'd1);
    drive(12'hD02, 1'b0, 1'b0, 1'b1); step();
    head("d2", 12'hD02, 1'b0, 1'b0);
    check("d2_err", 32'(frame_err), 32'd0);
    drive(12'hD03, 1'b0, 1'b0, 1'b1); step();
    head("d3", 12'hD03, 1'b0, 1'b0);
    drive(12'hD04, 1'b0, 1'b1, 1'b1); step();
    head("d4", 12'hD04, 1'b0, 1'b1);
    check("d4_err", 32'(frame_err), 32'd0);
    drive(12'h000, 1'b0, 1'b0, 1'b0); step();
    check("d_end_valid", 32'(src_if.valid), 32'd0);

    // Asynchronous reset mid-frame with 5 entries stored
    src_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(12'hE00 + 12'(i), (i == 0), 1'b0, 1'b1);
      step();
    end
    drive(12'h000, 1'b0, 1'b0, 1'b0);
    check("pre_rst_fill", 32'(fill_level), 32'd5);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(src_if.valid), 32'd0);
    check("mid_rst_fill",  32'(fill_level),   32'd0);
    check("mid_rst_ready", 32'(snk_if.ready), 32'd1);
    check("mid_rst_data",  32'(src_if.data),  32'd0);
    check("mid_rst_sop",   32'(src_if.sop),   32'd0);
    step();
    reset = 1'b1;
    src_if.ready = 1'b1;
    step();

    // Clean frame after reset: sop is not treated as premature
    drive(12'hF00, 1'b1, 1'b0, 1'b1); step();
    head("f0", 12'hF00, 1'b1, 1'b0);
    check("f0_err", 32'(frame_err), 32'd0);
    drive(12'hF01, 1'b0, 1'b0, 1'b1); step();
    head("f1", 12'hF01, 1'b0, 1'b0);
    drive(12'hF02, 1'b0, 1'b0, 1'b1); step();
    head("f2", 12'hF02, 1'b0, 1'b0);
    drive(12'hF03, 1'b0, 1'b1, 1'b1); step();
    head("f3", 12'hF03, 1'b0, 1'b1);
    check("f3_err", 32'(frame_err), 32'd0);
    drive(12'h000, 1'b0, 1'b0, 1'b0); step();
    check("f_end_valid", 32'(src_if.valid), 32'd0);
    check("f_end_fill",  32'(fill_level),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_frame_fifo.md
Name: pixel_frame_fifo

Overview:
- Avalon-ST pixel buffer directly downstream of the filter selection stage, feeding the VGA/display output path.
- Absorbs back-pressure jitter between filter output and display sink.
- Realigns to frame boundaries: discards beats until a start-of-packet is seen.
- Optionally checks frame length and flags malformed frames.

Parameters:
- WIDTH, 12, pixel width in bits (RGB444).
- DEPTH, 16, FIFO entries; power of 2, minimum 4.
- FRAME_PIXELS, 76800, expected beats per frame, sop through eop inclusive (320x240).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  in  WIDTH  sink pixel.
- sop_in  in  1  sink start-of-packet.
- eop_in  in  1  sink end-of-packet.
- valid_in  in  1  sink beat valid.
- ready_out  out  1  back-pressure to upstream; 1 = can accept a beat.
- data_out  out  WIDTH  source pixel.
- sop_out  out  1  source start-of-packet.
- eop_out  out  1  source end-of-packet.
- valid_out  out  1  source beat valid.
- ready_in  in  1  back-pressure from downstream sink.
- fill_level  out  $clog2(DEPTH)+1  current number of stored entries.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Handshakes:
  - Sink beat accepted when valid_in & ready_out.
  - Source beat consumed when valid_out & ready_in.
- Storage:
  - Each entry holds {sop, eop, data}.
  - Circular buffer; read/write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - full when the pointers differ only in MSB; empty when equal.
- Output:
  - Show-ahead: valid_out = !empty.
  - data_out, sop_out and eop_out reflect the head entry; all 0 when empty.
- Readiness:
  - ready_out is a function of registered state only: !full, or 1 in WAIT_SOP (beats are discarded there).
  - ready_out is never combinationally dependent on ready_in.
  - When full, no write occurs even if a read happens the same cycle; the next cycle ready_out = 1.
- Latency: a beat accepted in cycle N is visible at valid_out in cycle N+1 if the FIFO was empty.
- Simultaneous accept and consume: fill_level is unchanged; both pointers advance.
- fill_level is registered and exact: 0..DEPTH.
- Input FSM, states WAIT_SOP and IN_FRAME:
  - WAIT_SOP: accepted beats without sop_in are dropped, not written.
  - WAIT_SOP, accepted beat with sop_in: written; pixel count loaded with 1; go to IN_FRAME. If eop_in is also set (1-beat frame), it is written and the state stays WAIT_SOP.
  - IN_FRAME: accepted beats are written and the count increments.
  - IN_FRAME, accepted beat with eop_in: written; go to WAIT_SOP.
  - IN_FRAME, accepted beat with sop_in (premature sop): written as the start of a new frame; count reloads to 1; frame_err pulses; stay in IN_FRAME.
- Counter:
  - Width $clog2(FRAME_PIXELS+1).
  - Saturates at its maximum; no wrap.
- Reset (asynchronous, may occur mid-frame):
  - Pointers, count and fill_level clear to 0.
  - FSM returns to WAIT_SOP.
  - valid_out, sop_out, eop_out, data_out and frame_err go to 0.
  - ready_out goes to 1.
  - Stored data is lost; the partial frame is not flushed downstream.

Optional Feature:
- Macro: PIXEL_FRAME_FIFO_LENCHECK_EN.
- Defined:
  - On an accepted eop in IN_FRAME, frame_err pulses if the final count != FRAME_PIXELS.
  - frame_err also pulses on a premature sop, as described above.
  - The frame is still forwarded unchanged.
- Undefined:
  - No length comparison is made.
  - frame_err pulses only on a premature sop.
  - The comparator is removed.

Test Plan:
- Reset asserted (reset=0) mid-stream with 5 entries stored -> same cycle: valid_out=0, fill_level=0, ready_out=1; after release, the next frame starts cleanly.
- Before any sop, 3 beats (0x111, 0x222, 0x333) with valid_in=1, ready_in=1 -> valid_out stays 0; ready_out=1; nothing written.
- FRAME_PIXELS=4; frame 0xA00..0xA03 with sop on first and eop on last; ready_in=1 -> output order 0xA00..0xA03, sop/eop aligned, 1-cycle latency, frame_err=0.
- ready_in=0, DEPTH=16, continuous valid_in inside a frame -> fill_level climbs to 16; ready_out=0 from the next cycle; then ready_in=1 for one cycle -> fill_level=15, ready_out=1.
- Full FIFO with valid_in=1 and ready_in=1 simultaneously -> no write that cycle; fill_level 16 -> 15; no data lost or duplicated.
- LENCHECK_EN, FRAME_PIXELS=4: 3-beat frame -> frame_err pulses on the eop cycle. Both builds: sop at beat 2 of a frame -> frame_err pulses; the new frame is forwarded intact.
